// File: rtl/multicycle_mem_responder.sv
// Memory-side responder for the multicycle core: one outstanding request, fixed access
// latency, word-addressed local storage, response held until the requester consumes it.
module multicycle_mem_responder #(
    parameter int unsigned MEM_DEPTH = 16384,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int unsigned IdxW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic [31:0] mem_q [MEM_DEPTH];

    logic        accept;
    logic        commit;
    logic        c_write;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_err;
    logic        mem_we;

    assign accept = req_valid && req_ready;

    // With LATENCY == 1 the commit edge is the accept edge, so the request is taken
    // straight from the inputs instead of the latched copy.
    assign c_write = (state_q == StIdle) ? req_write : wr_q;
    assign c_addr  = (state_q == StIdle) ? req_addr  : addr_q;
    assign c_wdata = (state_q == StIdle) ? req_wdata : wdata_q;

    // Full 30-bit word index compare so high addresses never alias into storage.
    assign c_err  = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= 32'(MEM_DEPTH));
    assign commit = (state_q != StResp) && (state_d == StResp);
    assign mem_we = commit && c_write && !c_err && !reset;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                if (count_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        count_d = count_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    count_d = LatM1;
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            StWait: begin
                count_d = count_q - 4'd1;
            end
            StResp: begin
                if (resp_ready) begin
                    error_d = 1'b0;
                end
            end
            default: begin
                count_d = '0;
            end
        endcase

        if (commit) begin
            error_d = c_err;
            rdata_d = (!c_err && !c_write) ? mem_q[c_addr[IdxW+1:2]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[c_addr[IdxW+1:2]] <= c_wdata;
        end
    end

    // Output logic
    always_comb begin
        req_ready  = (state_q == StIdle) && !reset;
        resp_valid = (state_q == StResp) && !reset;
        resp_rdata = rdata_q;
        resp_error = error_q;
    end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Randomized bench for multicycle_mem_responder: three instances (LATENCY 2, 1, 4) checked
// against a transaction-level memory model.
module tb_multicycle_mem_responder;

    localparam int unsigned Depth  = 16384;
    localparam int          NumDut = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [NumDut];
    logic        req_ready  [NumDut];
    logic        req_write  [NumDut];
    logic [31:0] req_addr   [NumDut];
    logic [31:0] req_wdata  [NumDut];
    logic        resp_valid [NumDut];
    logic        resp_ready [NumDut];
    logic [31:0] resp_rdata [NumDut];
    logic        resp_error [NumDut];
    logic [3:0]  dut_count  [NumDut];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_acc [NumDut];

    logic [31:0] ref_mem   [NumDut][256];
    bit          ref_known [NumDut][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NumDut; g++) begin : g_dut
        multicycle_mem_responder #(
            .MEM_DEPTH(Depth),
            .LATENCY  ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_error(resp_error[g])
        );
        assign dut_count[g] = u_dut.count_q;
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full access; called and returns at a negedge.
    task automatic do_txn(input int k, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall, input bit hold,
                          input bit chained);
        int          t;
        int          n;
        int          lat;
        int          w;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] held_rd;
        bit          chk_rd;

        lat          = lat_of(k);
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        req_valid[k] = 1'b1;
        resp_ready[k] = 1'b0;

        t = 0;
        while (req_ready[k] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", 32'(t < 20), 1);
        if (chained) check("accept_spacing", cyc - last_acc[k], lat + 1);
        last_acc[k] = cyc;

        exp_err = (addr[1:0] != 2'b00) || (addr[31:2] >= Depth);
        exp_rd  = '0;
        chk_rd  = 1'b1;
        if (!exp_err) begin
            w = int'(addr[31:2]);
            if (w >= 256) begin
                chk_rd = 1'b0;
            end else if (wr) begin
                ref_mem[k][w]   = wd;
                ref_known[k][w] = 1'b1;
            end else if (ref_known[k][w]) begin
                exp_rd = ref_mem[k][w];
            end else begin
                chk_rd = 1'b0;
            end
        end

        @(negedge clk);
        n = 1;
        if (!hold) req_valid[k] = 1'b0;
        while (resp_valid[k] !== 1'b1 && n < 20) begin
            check("wait_count", 32'(dut_count[k]), lat - n);
            check("wait_ready", 32'(req_ready[k]), 0);
            @(negedge clk);
            n++;
        end
        check("resp_latency", n, lat);
        check("resp_error", 32'(resp_error[k]), 32'(exp_err));
        if (chk_rd) check("resp_rdata", resp_rdata[k], exp_rd);
        held_rd = resp_rdata[k];

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid[k]), 1);
            check("stall_rdata", resp_rdata[k], held_rd);
            check("stall_error", 32'(resp_error[k]), 32'(exp_err));
            check("stall_ready", 32'(req_ready[k]), 0);
        end
        resp_ready[k] = 1'b1;
        @(negedge clk);
        check("post_valid", 32'(resp_valid[k]), 0);
        check("post_error", 32'(resp_error[k]), 0);
        check("post_rdata", resp_rdata[k], held_rd);
        check("post_ready", 32'(req_ready[k]), 1);
    endtask

    task automatic go_idle(input int k);
        req_valid[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int j = 0; j < NumDut; j++) begin
            check({tag, "_req_ready"}, 32'(req_ready[j]), 0);
            check({tag, "_resp_valid"}, 32'(resp_valid[j]), 0);
            check({tag, "_resp_error"}, 32'(resp_error[j]), 0);
            check({tag, "_resp_rdata"}, resp_rdata[j], 0);
        end
    endtask

    // Write accepted, then reset lands while it is still waiting: it must never commit.
    task automatic reset_mid_wait(input int k, input logic [31:0] addr, input logic [31:0] wd);
        int t;
        req_write[k]  = 1'b1;
        req_addr[k]   = addr;
        req_wdata[k]  = wd;
        req_valid[k]  = 1'b1;
        resp_ready[k] = 1'b0;
        t = 0;
        while (req_ready[k] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rst_accept_timeout", 32'(t < 20), 1);
        @(negedge clk);
        req_valid[k] = 1'b0;
        check("rst_pre_valid", 32'(resp_valid[k]), 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_resp", 32'(resp_valid[k]), 0);
            check("rst_ready", 32'(req_ready[k]), 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k;
        int          sel;
        int          w;
        logic [31:0] a;

        for (int j = 0; j < NumDut; j++) begin
            req_valid[j]  = 1'b0;
            req_write[j]  = 1'b0;
            req_addr[j]   = '0;
            req_wdata[j]  = '0;
            resp_ready[j] = 1'b0;
            last_acc[j]   = 0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        for (int j = 0; j < NumDut; j++) check("reset_release_ready", 32'(req_ready[j]), 1);

        // LATENCY=2: write/read, backpressure, errors, no index truncation
        do_txn(0, 1'b1, 32'h40, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        do_txn(0, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0);
        do_txn(0, 1'b0, 32'h40, 32'h0, 5, 1'b0, 1'b0);
        do_txn(0, 1'b1, 32'h42, 32'h11111111, 0, 1'b0, 1'b0);
        do_txn(0, 1'b1, Depth * 4, 32'h22222222, 0, 1'b0, 1'b0);
        do_txn(0, 1'b1, (Depth + 16) * 4, 32'h33333333, 1, 1'b0, 1'b0);
        do_txn(0, 1'b1, 32'hFFFF_FFFC, 32'h44444444, 0, 1'b0, 1'b0);
        do_txn(0, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0);

        // Reset mid-WAIT leaves the old contents of 0x80 in place
        do_txn(0, 1'b1, 32'h80, 32'hA5A50001, 0, 1'b0, 1'b0);
        reset_mid_wait(0, 32'h80, 32'h12345678);
        do_txn(0, 1'b0, 32'h80, 32'h0, 0, 1'b0, 1'b0);
        do_txn(0, 1'b0, 32'h40, 32'h0, 2, 1'b0, 1'b0);

        // LATENCY=1: back-to-back with req_valid held, accepts 2 cycles apart
        for (int i = 0; i < 4; i++) do_txn(1, 1'b1, 32'(i * 4), $urandom, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_txn(1, 1'b0, 32'(i * 4), 32'h0, 0, 1'b1, i != 0);
        go_idle(1);

        // LATENCY=4: held req_valid, single accept per IDLE visit, count 3,2,1
        do_txn(2, 1'b1, 32'h14, 32'hCAFEF00D, 0, 1'b1, 1'b0);
        do_txn(2, 1'b0, 32'h14, 32'h0, 0, 1'b1, 1'b1);
        go_idle(2);

        // Randomized traffic across all instances
        for (int i = 0; i < 90; i++) begin
            k   = int'($urandom_range(0, NumDut - 1));
            sel = int'($urandom_range(0, 9));
            w   = int'($urandom_range(0, 255));
            if (sel < 7) begin
                a = 32'(w * 4);
            end else if (sel == 7) begin
                a = 32'(w * 4) + 32'($urandom_range(1, 3));
            end else if (sel == 8) begin
                a = 32'((Depth + w) * 4);
            end else begin
                a = $urandom | 32'h8000_0000;
            end
            do_txn(k, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)),
                   1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
